// File: rtl/envelope_adsr_pkg.sv
`default_nettype none
// ============================================================================
// Module  : envelope_adsr_pkg
// Purpose : Shared constants and the envelope state type for envelope_adsr.
//           ENV_W_DEFAULT / VOLT_W_DEFAULT are the default level and sample
//           widths. env_state_t enumerates the five envelope phases.
// Revision: 1.0 - initial release
// ============================================================================
package envelope_adsr_pkg;

  localparam int VOLT_W_DEFAULT = 16;
  localparam int ENV_W_DEFAULT  = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_t;

endpackage : envelope_adsr_pkg
`default_nettype wire

// File: rtl/envelope_adsr_vca.sv
`default_nettype none
// ============================================================================
// Module  : env_vca
// Purpose : Two-stage voltage-controlled amplifier. Stage 1 registers the
//           signed sample times the unsigned level. Stage 2 registers the
//           product shifted right by ENV_W (floor), giving sample*level/2^ENV_W.
// Ports   : clk, rst (async, active-high)
//           in_voltage [VOLT_W] signed sample, in_dv sample strobe
//           level      [ENV_W]  unsigned gain (all ones ~ unity)
//           out_voltage[VOLT_W] scaled sample, out_dv strobe (2 clk after in_dv)
// Revision: 1.0 - initial release
// ============================================================================
module env_vca #(
  parameter int VOLT_W = 16,
  parameter int ENV_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [VOLT_W-1:0] in_voltage,
  input  logic              in_dv,
  input  logic [ENV_W-1:0]  level,
  output logic [VOLT_W-1:0] out_voltage,
  output logic              out_dv
);

  localparam int PROD_W = VOLT_W + ENV_W + 1;

  logic signed [PROD_W-1:0] prod_d;
  logic signed [PROD_W-1:0] prod_q;
  logic                     dv1_q;
  logic [VOLT_W-1:0]        out_voltage_q;
  logic                     out_dv_q;
  logic                     unused_prod_bits;

  // Level is zero-extended so it stays non-negative in the signed multiply.
  assign prod_d = $signed(in_voltage) * $signed({1'b0, level});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q        <= '0;
      dv1_q         <= 1'b0;
      out_voltage_q <= '0;
      out_dv_q      <= 1'b0;
    end else begin
      dv1_q    <= in_dv;
      out_dv_q <= dv1_q;
      if (in_dv) begin
        prod_q <= prod_d;
      end
      // Bit-selecting the upper field of a two's complement product is an
      // arithmetic shift with floor rounding; |gain| < 1 so it always fits.
      if (dv1_q) begin
        out_voltage_q <= prod_q[VOLT_W+ENV_W-1:ENV_W];
      end
    end
  end

  // Sign guard bit and fraction bits are dropped by the floor shift.
  assign unused_prod_bits = ^{prod_q[PROD_W-1], prod_q[ENV_W-1:0]};

  assign out_voltage = out_voltage_q;
  assign out_dv      = out_dv_q;

endmodule : env_vca
`default_nettype wire

// File: rtl/envelope_adsr.sv
`default_nettype none
// ============================================================================
// Module  : envelope_adsr
// Purpose : ADSR amplitude envelope. Tracks note gate edges through IDLE,
//           ATTACK, DECAY, SUSTAIN, RELEASE; steps the envelope level once per
//           input sample; scales each sample by the pre-update level.
// Ports   : clk, rst (async, active-high), gate (note on/off)
//           in_voltage/in_dv   : oscillator sample stream
//           attack_rate, decay_rate, sustain_level, release_rate : envelope
//           out_voltage/out_dv : enveloped sample stream (2 clk latency)
//           active             : 1 while the envelope is not IDLE
// Revision: 1.0 - initial release
// ============================================================================
module envelope_adsr
  import envelope_adsr_pkg::*;
#(
  parameter int VOLT_W = VOLT_W_DEFAULT,
  parameter int ENV_W  = ENV_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gate,
  input  logic [VOLT_W-1:0] in_voltage,
  input  logic              in_dv,
  input  logic [ENV_W-1:0]  attack_rate,
  input  logic [ENV_W-1:0]  decay_rate,
  input  logic [ENV_W-1:0]  sustain_level,
  input  logic [ENV_W-1:0]  release_rate,
  output logic [VOLT_W-1:0] out_voltage,
  output logic              out_dv,
  output logic              active
);

  localparam logic [ENV_W-1:0] ENV_MAX   = {ENV_W{1'b1}};
  localparam logic [ENV_W:0]   ENV_MAX_X = {1'b0, ENV_MAX};

  env_state_t       state_q, state_d;
  logic [ENV_W-1:0] level_q, level_d;
  logic             gate_q;

  logic             gate_rise;
  logic             gate_fall;
  logic [ENV_W:0]   attack_sum;
  logic [ENV_W:0]   decay_floor;

  assign gate_rise   = gate & ~gate_q;
  assign gate_fall   = ~gate & gate_q;
  // One extra bit so neither comparison can wrap.
  assign attack_sum  = {1'b0, level_q} + {1'b0, attack_rate};
  assign decay_floor = {1'b0, sustain_level} + {1'b0, decay_rate};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      level_q <= '0;
      gate_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      gate_q  <= gate;
    end
  end

  // Next-state logic. A taken gate edge has priority over a level step, so
  // the level holds on a tick that coincides with a transition.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (gate_rise && (state_q == ST_IDLE || state_q == ST_RELEASE)) begin
      state_d = ST_ATTACK;
    end else if (gate_fall && (state_q == ST_ATTACK || state_q == ST_DECAY ||
                               state_q == ST_SUSTAIN)) begin
      state_d = ST_RELEASE;
    end else if (in_dv) begin
      unique case (state_q)
        ST_ATTACK: begin
          if (attack_sum >= ENV_MAX_X) begin
            level_d = ENV_MAX;
            state_d = ST_DECAY;
          end else begin
            level_d = attack_sum[ENV_W-1:0];
          end
        end
        ST_DECAY: begin
          if ({1'b0, level_q} <= decay_floor) begin
            level_d = sustain_level;
            state_d = ST_SUSTAIN;
          end else begin
            level_d = level_q - decay_rate;
          end
        end
        ST_SUSTAIN: begin
          level_d = sustain_level;
        end
        ST_RELEASE: begin
          if (level_q <= release_rate) begin
            level_d = '0;
            state_d = ST_IDLE;
          end else begin
            level_d = level_q - release_rate;
          end
        end
        ST_IDLE: begin
          level_d = '0;
        end
        default: begin
          level_d = '0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Output logic: decoded straight from the state register.
  always_comb begin
    active = (state_q != ST_IDLE);
  end

  // Samples are scaled by the level held before this tick's update.
  env_vca #(
    .VOLT_W (VOLT_W),
    .ENV_W  (ENV_W)
  ) u_vca (
    .clk         (clk),
    .rst         (rst),
    .in_voltage  (in_voltage),
    .in_dv       (in_dv),
    .level       (level_q),
    .out_voltage (out_voltage),
    .out_dv      (out_dv)
  );

endmodule : envelope_adsr
`default_nettype wire

// File: tb/tb_envelope_adsr.sv
`default_nettype none
// ============================================================================
// Module  : tb_envelope_adsr
// Purpose : Self-checking bench for envelope_adsr: directed vector table,
//           hand sequences for edge cases and reset, then randomized traffic
//           against a behavioural envelope model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_envelope_adsr;

  logic        clk = 1'b0;
  logic        rst;
  logic        gate;
  logic        in_dv;
  logic [15:0] in_voltage;
  logic [15:0] attack_rate, decay_rate, sustain_level, release_rate;
  logic [15:0] out_voltage;
  logic        out_dv;
  logic        active;

  always #5 clk = ~clk;

  envelope_adsr #(.VOLT_W(16), .ENV_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .gate          (gate),
    .in_voltage    (in_voltage),
    .in_dv         (in_dv),
    .attack_rate   (attack_rate),
    .decay_rate    (decay_rate),
    .sustain_level (sustain_level),
    .release_rate  (release_rate),
    .out_voltage   (out_voltage),
    .out_dv        (out_dv),
    .active        (active)
  );

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_ATK = 1, M_DEC = 2, M_SUS = 3, M_REL = 4;
  int m_state, m_level;
  bit m_gate_q;
  bit p1_v, o_v;
  int p1_val, o_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE; m_level = 0; m_gate_q = 0;
    p1_v = 0; o_v = 0; p1_val = 0; o_val = 0;
  endtask

  task automatic model_step();
    bit rise, fall;
    longint prod;
    o_v = p1_v;
    if (p1_v) o_val = p1_val;
    if (in_dv) begin
      prod   = longint'($signed(in_voltage)) * longint'(m_level);
      p1_val = int'(prod >>> 16);
    end
    p1_v = in_dv;
    rise = gate && !m_gate_q;
    fall = !gate && m_gate_q;
    if (rise && (m_state == M_IDLE || m_state == M_REL)) begin
      m_state = M_ATK;
    end else if (fall && (m_state == M_ATK || m_state == M_DEC || m_state == M_SUS)) begin
      m_state = M_REL;
    end else if (in_dv) begin
      case (m_state)
        M_ATK: if (m_level + int'(attack_rate) >= 65535) begin
                 m_level = 65535; m_state = M_DEC;
               end else m_level = m_level + int'(attack_rate);
        M_DEC: if (m_level <= int'(sustain_level) + int'(decay_rate)) begin
                 m_level = int'(sustain_level); m_state = M_SUS;
               end else m_level = m_level - int'(decay_rate);
        M_SUS: m_level = int'(sustain_level);
        M_REL: if (m_level <= int'(release_rate)) begin
                 m_level = 0; m_state = M_IDLE;
               end else m_level = m_level - int'(release_rate);
        default: m_level = 0;
      endcase
    end
    m_gate_q = gate;
  endtask

  task automatic check_model();
    logic [31:0] ov;
    ov = o_val;
    check("out_dv", {31'd0, out_dv}, {31'd0, o_v});
    check("out_voltage", {16'd0, out_voltage}, {16'd0, ov[15:0]});
    check("active", {31'd0, active}, {31'd0, (m_state != M_IDLE)});
    check("level", {16'd0, dut.level_q}, m_level);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          g;
    bit          dv;
    logic [15:0] vin;
    logic [15:0] sus;
    logic [15:0] exp_level;
    bit          exp_active;
    bit          chk_out;
    logic [15:0] exp_out;
  } vec_t;

  vec_t tbl[18];

  initial begin
    tbl[0]  = '{1, 0, 16'h0000, 16'hE000, 16'h0000, 1, 0, 16'h0000};
    tbl[1]  = '{1, 1, 16'h7FFF, 16'hE000, 16'h4000, 1, 0, 16'h0000};
    tbl[2]  = '{1, 1, 16'h7FFF, 16'hE000, 16'h8000, 1, 0, 16'h0000};
    tbl[3]  = '{1, 1, 16'h7FFF, 16'hE000, 16'hC000, 1, 1, 16'h1FFF};
    tbl[4]  = '{1, 1, 16'h0000, 16'hE000, 16'hFFFF, 1, 1, 16'h3FFF};
    tbl[5]  = '{1, 1, 16'h0000, 16'hE000, 16'hEFFF, 1, 0, 16'h0000};
    tbl[6]  = '{1, 1, 16'h0000, 16'hE000, 16'hE000, 1, 0, 16'h0000};
    tbl[7]  = '{1, 1, 16'h0000, 16'hD000, 16'hD000, 1, 0, 16'h0000};
    tbl[8]  = '{1, 1, 16'h0000, 16'hE000, 16'hE000, 1, 0, 16'h0000};
    tbl[9]  = '{0, 1, 16'h0000, 16'hE000, 16'hE000, 1, 0, 16'h0000};
    tbl[10] = '{0, 1, 16'h0000, 16'hE000, 16'h6000, 1, 0, 16'h0000};
    tbl[11] = '{1, 0, 16'h0000, 16'hE000, 16'h6000, 1, 0, 16'h0000};
    tbl[12] = '{1, 1, 16'h0000, 16'hE000, 16'hA000, 1, 0, 16'h0000};
    tbl[13] = '{0, 0, 16'h0000, 16'hE000, 16'hA000, 1, 0, 16'h0000};
    tbl[14] = '{0, 1, 16'h0000, 16'hE000, 16'h2000, 1, 0, 16'h0000};
    tbl[15] = '{0, 1, 16'h0000, 16'hE000, 16'h0000, 0, 0, 16'h0000};
    tbl[16] = '{0, 1, 16'h8000, 16'hE000, 16'h0000, 0, 0, 16'h0000};
    tbl[17] = '{0, 1, 16'h0000, 16'hE000, 16'h0000, 0, 1, 16'h0000};
  end

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1; gate = 0; in_dv = 0; in_voltage = '0;
    attack_rate = 16'h4000; decay_rate = 16'h1000;
    sustain_level = 16'hE000; release_rate = 16'h8000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_voltage", {16'd0, out_voltage}, 32'd0);
    check("reset_out_dv", {31'd0, out_dv}, 32'd0);
    check("reset_active", {31'd0, active}, 32'd0);
    rst = 1'b0;

    // Directed ADSR walk
    for (int i = 0; i < 18; i++) begin
      gate = tbl[i].g; in_dv = tbl[i].dv; in_voltage = tbl[i].vin;
      sustain_level = tbl[i].sus;
      tick();
      check($sformatf("tbl%0d_level", i), {16'd0, dut.level_q}, {16'd0, tbl[i].exp_level});
      check($sformatf("tbl%0d_active", i), {31'd0, active}, {31'd0, tbl[i].exp_active});
      if (tbl[i].chk_out) begin
        check($sformatf("tbl%0d_out", i), {16'd0, out_voltage}, {16'd0, tbl[i].exp_out});
        check($sformatf("tbl%0d_out_dv", i), {31'd0, out_dv}, 32'd1);
      end
    end

    // Floor rounding at full scale: 0x8000 * 0xFFFF -> 0x8000
    in_dv = 0; gate = 0; tick();
    attack_rate = 16'hFFFF;
    gate = 1; in_dv = 0; tick();                      // IDLE -> ATTACK
    gate = 1; in_dv = 1; in_voltage = 16'h0000; tick(); // level FFFF, DECAY
    check("edge_level_ffff", {16'd0, dut.level_q}, 32'h0000FFFF);
    in_voltage = 16'h8000; tick();                     // sample at FFFF
    in_dv = 0; in_voltage = 16'h0000; tick();
    check("edge_floor_out", {16'd0, out_voltage}, 32'h00008000);
    check("edge_floor_dv", {31'd0, out_dv}, 32'd1);
    tick();
    check("edge_dv_single", {31'd0, out_dv}, 32'd0);
    // Gate fall coinciding with in_dv holds the level
    gate = 0; in_dv = 1; tick();
    check("coincide_hold", {16'd0, dut.level_q}, 32'h0000EFFF);
    check("coincide_active", {31'd0, active}, 32'd1);
    // Back-to-back samples: out_dv every cycle, two clocks behind
    for (int i = 0; i < 6; i++) begin
      in_voltage = 16'(i * 16'h1111);
      tick();
      if (i >= 2) check("b2b_dv", {31'd0, out_dv}, 32'd1);
    end

    // Asynchronous reset mid-attack
    in_dv = 0; gate = 0;
    repeat (20) begin in_dv = 1; tick(); end           // drain to IDLE
    attack_rate = 16'h4000; gate = 1; in_dv = 0; tick();
    in_dv = 1; in_voltage = 16'h7FFF; tick(); tick(); tick();
    check("pre_rst_active", {31'd0, active}, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("arst_out_voltage", {16'd0, out_voltage}, 32'd0);
    check("arst_out_dv", {31'd0, out_dv}, 32'd0);
    check("arst_active", {31'd0, active}, 32'd0);
    check("arst_level", {16'd0, dut.level_q}, 32'd0);
    model_reset();
    gate = 0; in_dv = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    check("post_rst_active", {31'd0, active}, 32'd0);
    check("post_rst_level", {16'd0, dut.level_q}, 32'd0);

    // Randomized traffic against the model
    begin
      bit burst;
      burst = 0;
      for (int c = 0; c < 3000; c++) begin
        if (c % 50 == 0) begin
          attack_rate  = 16'($urandom_range(1, 16'h3000));
          decay_rate   = 16'($urandom_range(1, 16'h2000));
          release_rate = 16'($urandom_range(1, 16'h3000));
          burst        = ($urandom_range(0, 3) == 0);
        end
        if ($urandom_range(0, 99) < 3) sustain_level = 16'($urandom());
        if ($urandom_range(0, 29) == 0) gate = ~gate;
        in_dv      = burst ? 1'b1 : 1'($urandom_range(0, 1));
        in_voltage = 16'($urandom());
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_envelope_adsr
`default_nettype wire
